axi_wr_arbiter: RTL and testbench

//  Round-robin write-path arbiter sharing one AXI slave port (AW/W/B) between NUM_M masters.

---
 rtl/axi_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/axi_wr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and default widths for the AXI write-path arbiter and its
// read-path sibling.
package axi_arb_pkg;

  localparam int IDW_DEF = 4;
  localparam int AW_DEF  = 32;
  localparam int DW_DEF  = 32;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  typedef struct packed {
    logic [IDW_DEF-1:0] id;
    logic [AW_DEF-1:0]  addr;
    logic [3:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
  } aw_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester
// at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI write arbiter: one transaction at a time from grant through
// AW, all W beats and the B response, then release back to IDLE.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int IDW   = IDW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [NUM_M*IDW-1:0]   m_awid,
  input  logic [NUM_M*AW-1:0]    m_awaddr,
  input  logic [NUM_M*4-1:0]     m_awlen,
  input  logic [NUM_M*3-1:0]     m_awsize,
  input  logic [NUM_M*2-1:0]     m_awburst,
  input  logic [NUM_M-1:0]       m_awvalid,
  output logic [NUM_M-1:0]       m_awready,
  input  logic [NUM_M*IDW-1:0]   m_wid,
  input  logic [NUM_M*DW-1:0]    m_wdata,
  input  logic [NUM_M*DW/8-1:0]  m_wstrb,
  input  logic [NUM_M-1:0]       m_wlast,
  input  logic [NUM_M-1:0]       m_wvalid,
  output logic [NUM_M-1:0]       m_wready,
  output logic [IDW-1:0]         m_bid,
  output logic [1:0]             m_bresp,
  output logic [NUM_M-1:0]       m_bvalid,
  input  logic [NUM_M-1:0]       m_bready,
  output logic [IDW-1:0]         s_awid,
  output logic [AW-1:0]          s_awaddr,
  output logic [3:0]             s_awlen,
  output logic [2:0]             s_awsize,
  output logic [1:0]             s_awburst,
  output logic                   s_awvalid,
  input  logic                   s_awready,
  output logic [IDW-1:0]         s_wid,
  output logic [DW-1:0]          s_wdata,
  output logic [DW/8-1:0]        s_wstrb,
  output logic                   s_wlast,
  output logic                   s_wvalid,
  input  logic                   s_wready,
  input  logic [IDW-1:0]         s_bid,
  input  logic [1:0]             s_bresp,
  input  logic                   s_bvalid,
  output logic                   s_bready,
  output logic [NUM_M-1:0]       grant,
  output logic                   wlast_err
);

  localparam int SW = DW / 8;
  localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  state_e            state, state_nx;
  logic [NUM_M-1:0]  arb_gnt;
  logic [PW-1:0]     rr_ptr, gidx, win;
  logic [3:0]        beat_cnt, len_q;
  logic              beat_last, aw_hs, w_hs, b_hs;

  rr_arbiter #(.N(NUM_M)) u_rr (
    .req (m_awvalid),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_M; i++)
      if (arb_gnt[i]) win = PW'(i);
  end

  // The beat counter, not the master's WLAST, decides where the burst ends.
  assign beat_last = (beat_cnt == len_q);
  assign aw_hs     = (state == ADDR) && m_awvalid[gidx] && s_awready;
  assign w_hs      = (state == DATA) && m_wvalid[gidx] && s_wready;
  assign b_hs      = (state == RESP) && s_bvalid && m_bready[gidx];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|m_awvalid)         state_nx = ADDR;
      ADDR:    if (aw_hs)              state_nx = DATA;
      DATA:    if (w_hs && beat_last)  state_nx = RESP;
      RESP:    if (b_hs)               state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_awid    = '0;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_awsize  = '0;
    s_awburst = '0;
    s_awvalid = 1'b0;
    m_awready = '0;
    s_wid     = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    s_wvalid  = 1'b0;
    m_wready  = '0;
    s_bready  = 1'b0;
    m_bvalid  = '0;
    m_bid     = '0;
    m_bresp   = '0;
    case (state)
      ADDR: begin
        s_awid    = m_awid[gidx*IDW +: IDW];
        s_awaddr  = m_awaddr[gidx*AW +: AW];
        s_awlen   = m_awlen[gidx*4 +: 4];
        s_awsize  = m_awsize[gidx*3 +: 3];
        s_awburst = m_awburst[gidx*2 +: 2];
        s_awvalid = m_awvalid[gidx];
        m_awready = grant & {NUM_M{s_awready}};
      end
      DATA: begin
        s_wid    = m_wid[gidx*IDW +: IDW];
        s_wdata  = m_wdata[gidx*DW +: DW];
        s_wstrb  = m_wstrb[gidx*SW +: SW];
        s_wlast  = beat_last;
        s_wvalid = m_wvalid[gidx];
        m_wready = grant & {NUM_M{s_wready}};
      end
      RESP: begin
        s_bready = m_bready[gidx];
        m_bvalid = grant & {NUM_M{s_bvalid}};
        m_bid    = s_bid;
        m_bresp  = s_bresp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      grant     <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      len_q     <= '0;
      wlast_err <= 1'b0;
    end else begin
      state     <= state_nx;
      wlast_err <= w_hs && (m_wlast[gidx] != beat_last);
      case (state)
        IDLE: if (|m_awvalid) begin
          grant  <= arb_gnt;
          gidx   <= win;
          rr_ptr <= (win == PW'(NUM_M - 1)) ? '0 : win + PW'(1);
        end
        ADDR: if (aw_hs) begin
          len_q    <= m_awlen[gidx*4 +: 4];
          beat_cnt <= '0;
        end
        DATA: if (w_hs) beat_cnt <= beat_cnt + 4'd1;
        RESP: if (b_hs) grant <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed plus randomized bench for axi_wr_arbiter; a round-robin queue model
// predicts the owner and per-beat data, WLAST and wlast_err of each transaction.
module tb_axi_wr_arbiter;

  localparam int NUM_M = 2;
  localparam int IDW   = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;

  logic                  ACLK = 1'b0;
  logic                  ARESETn = 1'b0;
  logic [NUM_M*IDW-1:0]  m_awid = '0;
  logic [NUM_M*AW-1:0]   m_awaddr = '0;
  logic [NUM_M*4-1:0]    m_awlen = '0;
  logic [NUM_M*3-1:0]    m_awsize = '0;
  logic [NUM_M*2-1:0]    m_awburst = '0;
  logic [NUM_M-1:0]      m_awvalid = '0;
  logic [NUM_M-1:0]      m_awready;
  logic [NUM_M*IDW-1:0]  m_wid = '0;
  logic [NUM_M*DW-1:0]   m_wdata = '0;
  logic [NUM_M*SW-1:0]   m_wstrb = '0;
  logic [NUM_M-1:0]      m_wlast = '0;
  logic [NUM_M-1:0]      m_wvalid = '0;
  logic [NUM_M-1:0]      m_wready;
  logic [IDW-1:0]        m_bid;
  logic [1:0]            m_bresp;
  logic [NUM_M-1:0]      m_bvalid;
  logic [NUM_M-1:0]      m_bready = '0;
  logic [IDW-1:0]        s_awid;
  logic [AW-1:0]         s_awaddr;
  logic [3:0]            s_awlen;
  logic [2:0]            s_awsize;
  logic [1:0]            s_awburst;
  logic                  s_awvalid;
  logic                  s_awready = 1'b0;
  logic [IDW-1:0]        s_wid;
  logic [DW-1:0]         s_wdata;
  logic [SW-1:0]         s_wstrb;
  logic                  s_wlast;
  logic                  s_wvalid;
  logic                  s_wready = 1'b0;
  logic [IDW-1:0]        s_bid = '0;
  logic [1:0]            s_bresp = '0;
  logic                  s_bvalid = 1'b0;
  logic                  s_bready;
  logic [NUM_M-1:0]      grant;
  logic                  wlast_err;

  axi_wr_arbiter #(.NUM_M(NUM_M), .IDW(IDW), .AW(AW), .DW(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .wlast_err(wlast_err)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;
  int model_ptr = 0;
  logic [AW-1:0]  req_addr [NUM_M];
  logic [3:0]     req_len  [NUM_M];
  logic [IDW-1:0] req_id   [NUM_M];
  logic [DW-1:0]  req_base [NUM_M];
  bit             pending  [NUM_M];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NUM_M; k++)
      if (pending[(model_ptr + k) % NUM_M]) return (model_ptr + k) % NUM_M;
    return -1;
  endfunction

  function automatic logic [NUM_M-1:0] onehot(input int m);
    logic [NUM_M-1:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  task automatic raise(input int m, input logic [AW-1:0] a, input logic [3:0] l,
                       input logic [DW-1:0] base);
    req_addr[m] = a;
    req_len[m]  = l;
    req_id[m]   = IDW'($urandom);
    req_base[m] = base;
    m_awaddr[m*AW +: AW]   = a;
    m_awlen[m*4 +: 4]      = l;
    m_awid[m*IDW +: IDW]   = req_id[m];
    m_awsize[m*3 +: 3]     = 3'd2;
    m_awburst[m*2 +: 2]    = 2'd1;
    m_awvalid[m]           = 1'b1;
    pending[m]             = 1'b1;
  endtask

  // wr_mode: 0 always ready, 1 alternating 1010, 2 random (master WVALID random too)
  // wl_mode: 0 correct WLAST, 1 random WLAST, 2 WLAST on beat 2 only
  task automatic serve(input int m, input int aw_dly, input int wr_mode, input int wl_mode,
                       input int b_dly, input int br_lo, input logic [1:0] bresp);
    logic [NUM_M-1:0] oh;
    logic [SW-1:0]    strb;
    int  b, cyc, c;
    bit  wv, wr, wl, hs, err, bv, br, done;
    oh = onehot(m);
    chk("idle_grant", 64'(grant), 64'(0));
    @(negedge ACLK);
    chk("grant", 64'(grant), 64'(oh));
    chk("s_awvalid", 64'(s_awvalid), 64'(1));
    for (int d = 0; d < aw_dly; d++) begin
      s_awready = 1'b0;
      #1;
      chk("aw_stall_addr", 64'(s_awaddr), 64'(req_addr[m]));
      chk("aw_stall_len", 64'(s_awlen), 64'(req_len[m]));
      chk("aw_stall_ready", 64'(m_awready), 64'(0));
      @(negedge ACLK);
    end
    s_awready = 1'b1;
    #1;
    chk("m_awready", 64'(m_awready), 64'(oh));
    chk("s_awvalid_hs", 64'(s_awvalid), 64'(1));
    chk("s_awaddr", 64'(s_awaddr), 64'(req_addr[m]));
    chk("s_awid", 64'(s_awid), 64'(req_id[m]));
    chk("s_awlen", 64'(s_awlen), 64'(req_len[m]));
    chk("s_awsize", 64'(s_awsize), 64'(2));
    chk("s_awburst", 64'(s_awburst), 64'(1));
    @(negedge ACLK);
    m_awvalid[m] = 1'b0;
    s_awready    = 1'b0;

    b = 0;
    cyc = 0;
    while (b <= int'(req_len[m]) && cyc < 300) begin
      wv = (wr_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
      wr = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1);
      wl = (wl_mode == 0) ? (b == int'(req_len[m])) :
           (wl_mode == 1) ? ($urandom_range(0, 1) == 1) : (b == 1);
      strb = SW'($urandom);
      for (int o = 0; o < NUM_M; o++)
        if (o != m) begin
          m_wvalid[o] = ($urandom_range(0, 1) == 1);
          m_wdata[o*DW +: DW] = DW'($urandom);
          m_wlast[o] = ($urandom_range(0, 1) == 1);
        end
      m_wvalid[m]          = wv;
      m_wdata[m*DW +: DW]  = req_base[m] + DW'(b);
      m_wstrb[m*SW +: SW]  = strb;
      m_wid[m*IDW +: IDW]  = req_id[m];
      m_wlast[m]           = wl;
      s_wready             = wr;
      #1;
      chk("s_wvalid", 64'(s_wvalid), 64'(wv));
      chk("m_wready", 64'(m_wready), 64'(wr ? oh : '0));
      hs = wv && wr;
      if (hs) begin
        chk("s_wdata", 64'(s_wdata), 64'(req_base[m] + DW'(b)));
        chk("s_wlast", 64'(s_wlast), 64'(b == int'(req_len[m])));
        chk("s_wstrb", 64'(s_wstrb), 64'(strb));
        chk("s_wid", 64'(s_wid), 64'(req_id[m]));
      end
      err = hs && (wl != (b == int'(req_len[m])));
      @(negedge ACLK);
      chk("wlast_err", 64'(wlast_err), 64'(err));
      if (hs) b++;
      cyc++;
    end
    chk("w_beats", 64'(b), 64'(int'(req_len[m]) + 1));
    m_wvalid = '0;
    m_wlast  = '0;
    s_wready = 1'b0;

    done = 1'b0;
    c = 0;
    while (!done && c < 100) begin
      bv = (c >= b_dly);
      br = (c >= br_lo);
      s_bvalid = bv;
      s_bid    = req_id[m];
      s_bresp  = bresp;
      m_bready = NUM_M'($urandom);
      m_bready[m] = br;
      #1;
      chk("s_bready", 64'(s_bready), 64'(br));
      chk("m_bvalid", 64'(m_bvalid), 64'(bv ? oh : '0));
      if (bv) begin
        chk("m_bid", 64'(m_bid), 64'(req_id[m]));
        chk("m_bresp", 64'(m_bresp), 64'(bresp));
      end
      done = bv && br;
      @(negedge ACLK);
      c++;
    end
    s_bvalid = 1'b0;
    m_bready = '0;
    chk("grant_release", 64'(grant), 64'(0));
  endtask

  task automatic next_txn(input int aw_dly, input int wr_mode, input int wl_mode,
                          input int b_dly, input int br_lo, input logic [1:0] bresp);
    int m;
    m = pick();
    if (m >= 0) begin
      serve(m, aw_dly, wr_mode, wl_mode, b_dly, br_lo, bresp);
      pending[m] = 1'b0;
      model_ptr  = (m + 1) % NUM_M;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [NUM_M-1:0] mask;
    for (int i = 0; i < NUM_M; i++) pending[i] = 1'b0;

    repeat (3) @(negedge ACLK);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_s_awvalid", 64'(s_awvalid), 64'(0));
    chk("rst_s_wvalid", 64'(s_wvalid), 64'(0));
    chk("rst_s_bready", 64'(s_bready), 64'(0));
    chk("rst_m_bvalid", 64'(m_bvalid), 64'(0));
    chk("rst_wlast_err", 64'(wlast_err), 64'(0));
    ARESETn = 1'b1;
    @(negedge ACLK);

    // single master, len 3, okay response
    raise(0, 32'h1000, 4'd3, 32'h11);
    next_txn(0, 0, 0, 0, 0, 2'b00);

    // simultaneous requests, then repeat to see the pointer wrap
    raise(0, 32'h2000, 4'd1, 32'h20);
    raise(1, 32'h3000, 4'd2, 32'h30);
    next_txn(0, 0, 0, 1, 0, 2'b00);
    next_txn(0, 0, 0, 0, 0, 2'b01);
    raise(0, 32'h2100, 4'd0, 32'h40);
    raise(1, 32'h3100, 4'd0, 32'h50);
    next_txn(0, 0, 0, 0, 0, 2'b00);
    next_txn(0, 0, 0, 0, 0, 2'b00);

    // AW backpressure and alternating W ready
    raise(0, 32'h4000, 4'd3, 32'hA0);
    next_txn(5, 1, 0, 0, 0, 2'b00);

    // early WLAST on beat 2, missing WLAST on beat 4
    raise(1, 32'h5000, 4'd3, 32'hB0);
    next_txn(0, 0, 2, 0, 0, 2'b00);

    // 16-beat burst, late B and stalled B ready
    raise(1, 32'h6000, 4'd15, 32'hC00);
    next_txn(0, 0, 0, 10, 13, 2'b10);

    // reset in the middle of the burst
    raise(0, 32'h7000, 4'd3, 32'hD0);
    @(negedge ACLK);
    chk("pre_rst_grant", 64'(grant), 64'(onehot(0)));
    s_awready = 1'b1;
    @(negedge ACLK);
    m_awvalid = '0;
    s_awready = 1'b0;
    m_wvalid[0] = 1'b1;
    m_wdata[0 +: DW] = 32'hD0;
    s_wready = 1'b1;
    @(negedge ACLK);
    m_wdata[0 +: DW] = 32'hD1;
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(grant), 64'(0));
    chk("mid_rst_s_wvalid", 64'(s_wvalid), 64'(0));
    chk("mid_rst_s_wlast", 64'(s_wlast), 64'(0));
    chk("mid_rst_m_wready", 64'(m_wready), 64'(0));
    chk("mid_rst_s_awvalid", 64'(s_awvalid), 64'(0));
    chk("mid_rst_wlast_err", 64'(wlast_err), 64'(0));
    m_wvalid = '0;
    s_wready = 1'b0;
    pending[0] = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    model_ptr = 0;
    @(negedge ACLK);
    raise(0, 32'h8000, 4'd1, 32'hE0);
    raise(1, 32'h9000, 4'd1, 32'hF0);
    next_txn(0, 0, 0, 0, 0, 2'b00);
    next_txn(0, 0, 0, 0, 0, 2'b00);
    raise(1, 32'h9100, 4'd2, 32'h100);
    next_txn(1, 0, 0, 2, 1, 2'b00);

    // randomized rounds
    repeat (25) begin
      mask = NUM_M'($urandom_range(1, (1 << NUM_M) - 1));
      for (int i = 0; i < NUM_M; i++)
        if (mask[i]) raise(i, AW'($urandom), 4'($urandom_range(0, 7)), DW'($urandom));
      for (int k = 0; k < NUM_M; k++)
        next_txn($urandom_range(0, 3), 2, 1, $urandom_range(0, 3), $urandom_range(0, 3),
                 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
